fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Control stage directly upstream of fetch_unit. Drives fetch_control, jump_addr and ra_addr.
//  Turns decoded jump, branch, call, return and stall requests into a fetch_unit command.
//  Keeps a hardware return-address stack (RAS) for calls and returns.
//  Squashes the wrong-path slot after every redirect with a hold/flush FSM.
//  Latches a fault when the stack overflows or underflows.
// PARAMETERS
//  RAS_DEPTH     4   number of return-address stack entries (1..16)
//  FLUSH_CYCLES  1   hold cycles inserted after a redirect (1..3)
// PORTS
//  clk            in   1   system clock; all state changes on its rising edge
//  reset          in   1   synchronous, active-high reset
//  stall          in   1   hold the PC this cycle (e.g. a memory wait)
//  ret_en         in   1   decoded return
//  call_en        in   1   decoded call to target_addr
//  jump_en        in   1   decoded unconditional jump to target_addr
//  branch_en      in   1   decoded conditional branch to target_addr
//  cond_flag      in   1   branch condition from the ALU flags; 1 = taken
//  target_addr    in   8   jump, call or branch target
//  instr_rd_addr  in   10  current PC, fed back from fetch_unit
//  fetch_control  out  2   00 = PC+1, 01 = jump, 10 = return, 11 = hold
//  jump_addr      out  8   target to fetch_unit
//  ra_addr        out  10  top of the RAS; 10'h000 when the stack is empty
//  ras_count      out  5   number of valid RAS entries
//  fault          out  1   sticky stack overflow/underflow flag
// BEHAVIOUR
//  Timing
//   - Outputs are combinational from the registered state and the current inputs.
//   - fetch_unit samples the outputs on the next rising edge.
//   - RAS and FSM updates happen on that same edge.
//  Reset (reset=1, sampled at the edge)
//   - state=RUN, ras_count=0, all stack entries=0, fault=0, flush counter=0.
//   - While reset is high: fetch_control=2'b11, jump_addr=8'h00.
//  FSM states: RUN, FLUSH, HALT.
//  RUN, requests resolved in this priority order:
//   1. stall=1
//      -> fetch_control=11; no push/pop; stay in RUN; all other requests ignored.
//   2. ret_en
//      - stack non-empty: fetch_control=10, ra_addr=top; pop at the edge; go to FLUSH.
//      - stack empty: fetch_control=11; set fault; go to HALT.
//   3. call_en
//      - stack not full: fetch_control=01, jump_addr=target_addr;
//        push (instr_rd_addr+1) mod 1024 (10'h3FF+1 -> 10'h000); go to FLUSH.
//      - stack full: fetch_control=11; set fault; go to HALT; no push.
//   4. jump_en, or branch_en with cond_flag=1
//      -> fetch_control=01, jump_addr=target_addr; go to FLUSH.
//   5. Otherwise (branch not taken, or no request)
//      -> fetch_control=00, jump_addr=8'h00.
//  Lower-priority requests in the same cycle are discarded, not queued.
//  FLUSH
//   - fetch_control=11 for exactly FLUSH_CYCLES cycles.
//   - All request inputs, including stall, are ignored; then return to RUN.
//   - The stack is unchanged during FLUSH.
//  HALT
//   - fetch_control=11 every cycle; fault=1; the stack is frozen.
//   - Only reset leaves HALT.
//  RAS
//   - LIFO; ra_addr always shows the entry at index ras_count-1.
//   - ras_count stays in 0..RAS_DEPTH; it never wraps.
//  Reset mid-FLUSH or in HALT: returns to RUN with an empty stack on the next edge.
// TESTING
//  1. Release reset, then 4 idle cycles
//     -> fetch_control=00 every cycle; ras_count=0; fault=0.
//  2. call_en, target_addr=8'hA5, PC=10'h010
//     -> fetch_control=01, jump_addr=A5; next cycle ra_addr=10'h011, ras_count=1,
//        fetch_control=11 for 1 cycle, then 00.
//  3. Follow-up to 2: ret_en
//     -> fetch_control=10, ra_addr=10'h011; after the edge ras_count=0; 1 hold cycle.
//  4. PC=10'h3FF with 4 calls (RAS_DEPTH=4), then a 5th call
//     -> first push is 10'h000; the 5th call gives fault=1, fetch_control=11 until reset.
//  5. ret_en with an empty stack
//     -> fault=1, HALT; a later reset gives fetch_control=00, fault=0.
//  6. branch_en with cond_flag=0, then with cond_flag=1; separately stall+jump_en together
//     -> 00, then 01 with jump_addr=target_addr; stall+jump_en gives 11 with no redirect.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Request/command bundle between the decoder side and fetch_sequencer.
// The sequencer attaches through the slave modport.
interface fetch_sequencer_if;
  logic       stall;
  logic       ret_en;
  logic       call_en;
  logic       jump_en;
  logic       branch_en;
  logic       cond_flag;
  logic [7:0] target_addr;
  logic [9:0] instr_rd_addr;
  logic [1:0] fetch_control;
  logic [7:0] jump_addr;
  logic [9:0] ra_addr;
  logic [4:0] ras_count;
  logic       fault;

  modport master (
    output stall, ret_en, call_en, jump_en,
    output branch_en, cond_flag,
    output target_addr, instr_rd_addr,
    input  fetch_control, jump_addr,
    input  ra_addr, ras_count, fault
  );

  modport slave (
    input  stall, ret_en, call_en, jump_en,
    input  branch_en, cond_flag,
    input  target_addr, instr_rd_addr,
    output fetch_control, jump_addr,
    output ra_addr, ras_count, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch command sequencer: redirects, return-address stack,
// post-redirect hold/flush and sticky stack fault.
module fetch_sequencer #(
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [1:0] CTL_SEQ  = 2'b00;
  localparam logic [1:0] CTL_JMP  = 2'b01;
  localparam logic [1:0] CTL_RET  = 2'b10;
  localparam logic [1:0] CTL_HOLD = 2'b11;

  localparam logic [4:0] DEPTH = 5'(RAS_DEPTH);
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] ras_count;
  logic [1:0] flush_cnt;
  logic [1:0] flush_nxt;
  logic       fault_q;
  logic       fault_nxt;
  logic       push;
  logic       pop;
  logic [1:0] ctl;
  logic [7:0] jaddr;
  logic [9:0] top;
  logic [9:0] push_val;
  logic [9:0] stack [RAS_DEPTH];

  logic empty;
  logic full;
  logic do_stall;
  logic do_ret;
  logic do_call;
  logic do_jump;

  assign empty    = (ras_count == 5'd0);
  assign full     = (ras_count == DEPTH);
  assign push_val = bus.instr_rd_addr + 10'd1;

  // Mask lower-priority requests so the decoder cases are one-hot.
  assign do_stall = bus.stall;
  assign do_ret   = !bus.stall && bus.ret_en;
  assign do_call  = !bus.stall && !bus.ret_en
                 && bus.call_en;
  assign do_jump  = !bus.stall && !bus.ret_en
                 && !bus.call_en
                 && (bus.jump_en
                  || (bus.branch_en && bus.cond_flag));

  always_comb begin
    top = '0;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (5'(i) + 5'd1 == ras_count) top = stack[i];
    end
  end

  always_comb begin
    state_nxt = state;
    flush_nxt = flush_cnt;
    fault_nxt = fault_q;
    push      = 1'b0;
    pop       = 1'b0;
    ctl       = CTL_SEQ;
    jaddr     = 8'h00;
    unique case (state)
      RUN: begin
        unique case (1'b1)
          do_stall: ctl = CTL_HOLD;
          do_ret: begin
            if (empty) begin
              ctl       = CTL_HOLD;
              fault_nxt = 1'b1;
              state_nxt = HALT;
            end else begin
              ctl       = CTL_RET;
              pop       = 1'b1;
              state_nxt = FLUSH;
              flush_nxt = FLUSH_LAST;
            end
          end
          do_call: begin
            if (full) begin
              ctl       = CTL_HOLD;
              fault_nxt = 1'b1;
              state_nxt = HALT;
            end else begin
              ctl       = CTL_JMP;
              jaddr     = bus.target_addr;
              push      = 1'b1;
              state_nxt = FLUSH;
              flush_nxt = FLUSH_LAST;
            end
          end
          do_jump: begin
            ctl       = CTL_JMP;
            jaddr     = bus.target_addr;
            state_nxt = FLUSH;
            flush_nxt = FLUSH_LAST;
          end
          default: ;
        endcase
      end
      FLUSH: begin
        ctl = CTL_HOLD;
        if (flush_cnt == 2'd0) state_nxt = RUN;
        else flush_nxt = flush_cnt - 2'd1;
      end
      HALT: ctl = CTL_HOLD;
      default: state_nxt = RUN;
    endcase
    if (reset) begin
      ctl   = CTL_HOLD;
      jaddr = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      ras_count <= '0;
      flush_cnt <= '0;
      fault_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
      fault_q   <= fault_nxt;
      if (push) ras_count <= ras_count + 5'd1;
      else if (pop) ras_count <= ras_count - 5'd1;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (push && 5'(i) == ras_count) stack[i] <= push_val;
      end
    end
  end

  assign bus.fetch_control = ctl;
  assign bus.jump_addr     = jaddr;
  assign bus.ra_addr       = top;
  assign bus.ras_count     = ras_count;
  assign bus.fault         = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer
// (RAS_DEPTH=4, FLUSH_CYCLES=1).
module tb_fetch_sequencer;

  typedef struct {
    int ctl;
    int ja;
    int ra;
    int cnt;
    int flt;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   stepno;
  exp_t sb[$];

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RAS_DEPTH   (4),
    .FLUSH_CYCLES(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs,
                     int exp);
    logic [31:0] e;
    if (exp < 0) return;
    e = exp;
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, e);
    end
  endtask

  // One cycle: drive inputs after the falling edge, queue the
  // expected outputs, then pop and compare before the rising edge.
  // An expected value of -1 means "not checked this cycle".
  task automatic step(
    logic rst, logic s, logic r, logic c,
    logic j, logic b, logic f,
    logic [7:0] tgt, logic [9:0] pc,
    int ectl, int eja, int era, int ecnt, int eflt);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset             = rst;
    bus.stall         = s;
    bus.ret_en        = r;
    bus.call_en       = c;
    bus.jump_en       = j;
    bus.branch_en     = b;
    bus.cond_flag     = f;
    bus.target_addr   = tgt;
    bus.instr_rd_addr = pc;
    e = '{ectl, eja, era, ecnt, eflt};
    sb.push_back(e);
    #2;
    stepno++;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL s%0d.queue empty", stepno);
    end else begin
      got = sb.pop_front();
      chk($sformatf("s%0d.ctl", stepno),
          32'(bus.fetch_control), got.ctl);
      chk($sformatf("s%0d.jaddr", stepno),
          32'(bus.jump_addr), got.ja);
      chk($sformatf("s%0d.ra", stepno),
          32'(bus.ra_addr), got.ra);
      chk($sformatf("s%0d.cnt", stepno),
          32'(bus.ras_count), got.cnt);
      chk($sformatf("s%0d.fault", stepno),
          32'(bus.fault), got.flt);
    end
  endtask

  task automatic idle(int ectl, int era,
                      int ecnt, int eflt);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 10'h000,
         ectl, 0, era, ecnt, eflt);
  endtask

  task automatic call(logic [7:0] t, logic [9:0] pc,
                      int ectl, int eja, int era,
                      int ecnt, int eflt);
    step(0, 0, 0, 1, 0, 0, 0, t, pc,
         ectl, eja, era, ecnt, eflt);
  endtask

  task automatic ret(int ectl, int era,
                     int ecnt, int eflt);
    step(0, 0, 1, 0, 0, 0, 0, 8'h00, 10'h000,
         ectl, -1, era, ecnt, eflt);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    stepno      = 0;

    // Reset held: hold command, zero target.
    step(1, 0, 0, 0, 0, 0, 0, 8'hFF, 10'h000,
         3, 0, -1, -1, -1);
    step(1, 0, 0, 0, 0, 0, 0, 8'hFF, 10'h000,
         3, 0, 0, 0, 0);

    // Idle after reset.
    for (int i = 0; i < 4; i++) idle(0, 0, 0, 0);

    // Call, flush (jump ignored), then sequential.
    call(8'hA5, 10'h010, 1, 8'hA5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 8'h33, 10'h000,
         3, -1, 10'h011, 1, 0);
    idle(0, 10'h011, 1, 0);

    // Return pops, then one hold cycle.
    ret(2, 10'h011, 1, 0);
    idle(3, 0, 0, 0);
    idle(0, 0, 0, 0);

    // Fill the stack; first push wraps 3FF+1 to 000.
    call(8'h10, 10'h3FF, 1, 8'h10, 0, 0, 0);
    idle(3, 10'h000, 1, 0);
    call(8'h11, 10'h020, 1, 8'h11, 10'h000, 1, 0);
    idle(3, 10'h021, 2, 0);
    call(8'h12, 10'h030, 1, 8'h12, 10'h021, 2, 0);
    idle(3, 10'h031, 3, 0);
    call(8'h13, 10'h040, 1, 8'h13, 10'h031, 3, 0);
    idle(3, 10'h041, 4, 0);

    // LIFO order: pop 041, expose 031, refill.
    ret(2, 10'h041, 4, 0);
    idle(3, 10'h031, 3, 0);
    call(8'h14, 10'h060, 1, 8'h14, 10'h031, 3, 0);
    idle(3, 10'h061, 4, 0);

    // Overflow: hold, fault, then HALT ignores requests.
    call(8'h15, 10'h070, 3, -1, 10'h061, 4, 0);
    idle(3, 10'h061, 4, 1);
    step(0, 0, 0, 0, 1, 0, 0, 8'h44, 10'h000,
         3, -1, 10'h061, 4, 1);
    step(1, 0, 0, 0, 0, 0, 0, 8'h00, 10'h000,
         3, 0, 10'h061, 4, 1);
    idle(0, 0, 0, 0);

    // Underflow.
    ret(3, 0, 0, 0);
    idle(3, 0, 0, 1);
    idle(3, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 8'h00, 10'h000,
         3, 0, 0, 0, 1);
    idle(0, 0, 0, 0);

    // Branch not taken, then taken.
    step(0, 0, 0, 0, 0, 1, 0, 8'h77, 10'h000,
         0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 8'h77, 10'h000,
         1, 8'h77, 0, 0, 0);
    idle(3, 0, 0, 0);
    idle(0, 0, 0, 0);

    // Stall beats jump and call: no redirect, no push.
    step(0, 1, 0, 0, 1, 0, 0, 8'h55, 10'h000,
         3, -1, 0, 0, 0);
    idle(0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 8'h56, 10'h100,
         3, -1, 0, 0, 0);
    idle(0, 0, 0, 0);

    // Call wins over a simultaneous jump.
    step(0, 0, 0, 1, 1, 0, 0, 8'h66, 10'h200,
         1, 8'h66, 0, 0, 0);

    // Reset during FLUSH empties the stack.
    step(1, 0, 0, 0, 0, 0, 0, 8'h00, 10'h000,
         3, 0, 10'h201, 1, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard residue=%0d expected=0",
               sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
